// File: rtl/branch_resolver.sv
// branch_resolver
//   Resolve-side partner of the IF-stage BTB lookup. Builds the IF taken/target
//   prediction from BTB hit data and a 2-bit direction table (PHT). It carries
//   that prediction IF->ID->EX in two metadata slots and checks it against the
//   EX outcome. It raises the flush/redirect and issues registered BTB installs
//   and PHT training.
//
// Ports
//   clk, rst            clock (rising edge); async active-high reset
//   stall               hold the ID/EX metadata slots
//   IF_valid, IF_pc     fetch-side instruction
//   hit, IF_Branch,
//   IF_Jump, pc_imm_out BTB lookup result for IF_pc
//   IF_pred_taken/target  comb prediction for the fetch PC mux
//   EX_valid, EX_pc, EX_Branch, EX_Jump, EX_taken, EX_target  EX outcome
//   mispredict, redirect_pc  comb flush + correct fetch PC
//   btb_write/pc/target/branch  registered BTB install request
//   branch_count, mispredict_count  wrapping statistics
module branch_resolver #(
  parameter int PHT_ENTRIES = 16,
  parameter int PHT_IDX_W   = 4,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  // IF side
  input  logic             IF_valid,
  input  logic [31:0]      IF_pc,
  input  logic             hit,
  input  logic             IF_Branch,
  input  logic             IF_Jump,
  input  logic [31:0]      pc_imm_out,
  output logic             IF_pred_taken,
  output logic [31:0]      IF_pred_target,
  // EX side
  input  logic             EX_valid,
  input  logic [31:0]      EX_pc,
  input  logic             EX_Branch,
  input  logic             EX_Jump,
  input  logic             EX_taken,
  input  logic [31:0]      EX_target,
  output logic             mispredict,
  output logic [31:0]      redirect_pc,
  // BTB install
  output logic             btb_write,
  output logic [31:0]      btb_pc,
  output logic [31:0]      btb_target,
  output logic             btb_branch,
  // statistics
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);

  // Prediction metadata that travels alongside the instruction.
  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        pred_hit;
  } slot_t;

  logic [PHT_ENTRIES-1:0][1:0] pht;
  logic [PHT_IDX_W-1:0]        if_idx, ex_idx;
  logic [1:0]                  pht_cur, pht_nxt;

  slot_t if_slot, id_q, ex_q;

  // Effective prediction seen by EX.
  logic        slot_match;
  logic        eff_taken, eff_hit;
  logic [31:0] eff_target;

  // Resolution terms.
  logic        ctrl, act, tgt_diff;
  logic        mis, install;
  logic [31:0] ex_fallthru;

  // ------------------------------------------------------------------
  // IF prediction
  // ------------------------------------------------------------------
  assign if_idx = IF_pc[PHT_IDX_W+1:2];

  // Jumps always predict taken on a hit; branches follow the PHT MSB.
  // The PHT read is combinational, so a same-edge update is not yet visible.
  assign IF_pred_taken  = hit && (IF_Jump || (IF_Branch && pht[if_idx][1]));
  assign IF_pred_target = IF_pred_taken ? pc_imm_out : IF_pc + 32'd4;

  always_comb begin
    if_slot             = '0;
    if_slot.valid       = IF_valid;
    if_slot.pc          = IF_pc;
    if_slot.pred_taken  = IF_pred_taken;
    if_slot.pred_target = IF_pred_target;
    if_slot.pred_hit    = hit;
  end

  // ------------------------------------------------------------------
  // EX resolution
  // ------------------------------------------------------------------
  // A slot is only trusted when it belongs to the instruction now in EX.
  // Otherwise (bubble, flushed slot, pipeline skew) treat it as "no prediction".
  assign slot_match = ex_q.valid && (ex_q.pc == EX_pc);
  assign eff_taken  = slot_match && ex_q.pred_taken;
  assign eff_hit    = slot_match && ex_q.pred_hit;
  assign eff_target = slot_match ? ex_q.pred_target : 32'd0;

  assign ctrl        = EX_Branch | EX_Jump;
  assign act         = ctrl & EX_taken;
  assign tgt_diff    = (eff_target != EX_target);
  assign ex_fallthru = EX_pc + 32'd4;    // wraps naturally at 2**32

  // A non-control instruction that was predicted taken (stale BTB alias)
  // falls out of this as act=0, pred=1 -> redirect to the fall-through.
  assign mis        = EX_valid & ((eff_taken != act) | (act & tgt_diff));
  assign mispredict = mis;
  assign redirect_pc = !mis ? 32'd0 : (act ? EX_target : ex_fallthru);

  // Install when the taken target is unknown to the BTB or stale there.
  assign install = EX_valid & act & (!eff_hit | tgt_diff);

  // ------------------------------------------------------------------
  // Metadata slots: flush beats stall
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_q <= '0;
      ex_q <= '0;
    end else if (mis) begin
      id_q <= '0;
      ex_q <= '0;
    end else if (!stall) begin
      id_q <= if_slot;
      ex_q <= id_q;
    end
  end

  // ------------------------------------------------------------------
  // PHT training (conditional branches only)
  // ------------------------------------------------------------------
  assign ex_idx  = EX_pc[PHT_IDX_W+1:2];
  assign pht_cur = pht[ex_idx];

  always_comb begin
    pht_nxt = pht_cur;
    if (EX_taken) begin
      if (pht_cur != 2'd3) pht_nxt = pht_cur + 2'd1;
    end else begin
      if (pht_cur != 2'd0) pht_nxt = pht_cur - 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      pht <= {PHT_ENTRIES{2'b01}};
    else if (EX_valid && EX_Branch)
      pht[ex_idx] <= pht_nxt;
  end

  // ------------------------------------------------------------------
  // BTB install request and statistics
  // ------------------------------------------------------------------
  // btb_write is a one-cycle strobe. The data fields keep the last install
  // so the BTB may sample them late without harm.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btb_write        <= 1'b0;
      btb_pc           <= 32'd0;
      btb_target       <= 32'd0;
      btb_branch       <= 1'b1;
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      btb_write <= install;
      if (install) begin
        btb_pc     <= EX_pc;
        btb_target <= EX_target;
        btb_branch <= EX_Branch;
      end
      if (EX_valid && ctrl) branch_count     <= branch_count + CNT_W'(1);
      if (mis)              mispredict_count <= mispredict_count + CNT_W'(1);
    end
  end

endmodule
